// File: rtl/apuf_ctrl_pkg.sv
// Shared types and constants for the arbiter-PUF evaluation controller.
package apuf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_FIRE    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RELAX   = 3'd4,
    ST_DONE    = 3'd5
  } apuf_state_e;

  // Fibonacci LFSR: taps 64,63,61,60 map to bits 63,62,60,59.
  localparam logic [63:0] LFSR_SEED = 64'h0000_0000_0000_0001;
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  // Ones count must exceed this value for a majority-1 response.
  function automatic int maj_thresh(input int n_eval);
    return n_eval / 2;
  endfunction

endpackage

// File: rtl/apuf_cyc_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module apuf_cyc_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer: fires the PUF N_EVAL times per challenge
// and returns the majority bit plus the raw ones count.
// Optional macro CHAL_LFSR_EN adds auto_mode and an on-chip challenge LFSR.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a challenge, PUF unpowered
// SETUP   | challenge applied, vcc on, settling before first trigger
// FIRE    | trigger high, waiting for respReady (watchdog running)
// CAPTURE | accumulate the sampled bit, drop trigger
// RELAX   | settle time and wait for respReady low (watchdog running)
// DONE    | result presented until the host takes it
module apuf_eval_ctrl
  import apuf_ctrl_pkg::*;
#(
  parameter int CHAL_W      = 64,
  parameter int N_EVAL      = 15,
  parameter int CNT_W       = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CHAL_LFSR_EN
  input  logic              auto_mode,
`endif
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [CHAL_W-1:0] chal_in,
  output logic [CHAL_W-1:0] c,
  output logic              vcc,
  output logic              tigSignal,
  input  logic              respReady,
  input  logic              respBit,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
  output logic [CNT_W-1:0]  ones_cnt,
  output logic              timeout_err
);

  localparam int TMR_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  apuf_state_e       state_q, state_d;
  logic [CHAL_W-1:0] c_q, c_d;
  logic              vcc_q, vcc_d;
  logic              tig_q, tig_d;
  logic              start_ready_q, start_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_bit_q, resp_bit_d;
  logic [CNT_W-1:0]  ones_cnt_q, ones_cnt_d;
  logic [CNT_W-1:0]  eval_cnt_q, eval_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              cap_bit_q, cap_bit_d;

  logic              settle_load, settle_exp;
  logic              wd_load, wd_exp;
  logic              go;
  logic [CHAL_W-1:0] chal_sel;

`ifdef CHAL_LFSR_EN
  logic [CHAL_W-1:0] lfsr_q, lfsr_d;
  logic              lfsr_fb;

  // Auto mode self-starts from the LFSR and ignores the host challenge.
  always_comb begin
    lfsr_fb  = ^(lfsr_q & LFSR_TAPS[CHAL_W-1:0]);
    go       = auto_mode | (start_valid & start_ready_q);
    chal_sel = auto_mode ? lfsr_q : chal_in;
    lfsr_d   = lfsr_q;
    if (state_q == ST_IDLE && auto_mode) begin
      lfsr_d = {lfsr_q[CHAL_W-2:0], lfsr_fb};
    end
  end

  // LFSR register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED[CHAL_W-1:0];
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  // Host-started transactions only.
  always_comb begin
    go       = start_valid & start_ready_q;
    chal_sel = chal_in;
  end
`endif

  // Settle timer covers SETUP and the minimum RELAX time.
  apuf_cyc_timer #(.W(TMR_W)) u_settle_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (settle_load),
    .load_val (TMR_W'(SETTLE_CYC - 1)),
    .expired  (settle_exp)
  );

  // Watchdog bounds both the wait for respReady and the wait for it to fall.
  apuf_cyc_timer #(.W(TMR_W)) u_wd_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (TMR_W'(TIMEOUT_CYC - 1)),
    .expired  (wd_exp)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    c_d           = c_q;
    resp_valid_d  = resp_valid_q;
    resp_bit_d    = resp_bit_q;
    ones_cnt_d    = ones_cnt_q;
    eval_cnt_d    = eval_cnt_q;
    timeout_err_d = timeout_err_q;
    cap_bit_d     = cap_bit_q;
    settle_load   = 1'b0;
    wd_load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          c_d           = chal_sel;
          ones_cnt_d    = '0;
          eval_cnt_d    = '0;
          timeout_err_d = 1'b0;
          settle_load   = 1'b1;
          state_d       = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (settle_exp) begin
          wd_load = 1'b1;
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        // RELAX guarantees respReady was low, so a high level here is fresh.
        if (respReady) begin
          cap_bit_d = respBit;
          state_d   = ST_CAPTURE;
        end else if (wd_exp) begin
          timeout_err_d = 1'b1;
          resp_bit_d    = 1'b0;
          resp_valid_d  = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_CAPTURE: begin
        ones_cnt_d  = ones_cnt_q + CNT_W'(cap_bit_q);
        eval_cnt_d  = eval_cnt_q + CNT_W'(1);
        settle_load = 1'b1;
        wd_load     = 1'b1;
        state_d     = ST_RELAX;
      end
      ST_RELAX: begin
        if (settle_exp && !respReady) begin
          if (eval_cnt_q == CNT_W'(N_EVAL)) begin
            resp_valid_d = 1'b1;
            resp_bit_d   = (ones_cnt_q > CNT_W'(maj_thresh(N_EVAL)));
            state_d      = ST_DONE;
          end else begin
            wd_load = 1'b1;
            state_d = ST_FIRE;
          end
        end else if (wd_exp && respReady) begin
          timeout_err_d = 1'b1;
          resp_bit_d    = 1'b0;
          resp_valid_d  = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered so the PUF sees these aligned with the state they belong to.
    vcc_d         = (state_d != ST_IDLE);
    tig_d         = (state_d == ST_FIRE);
    start_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      c_q           <= '0;
      vcc_q         <= 1'b0;
      tig_q         <= 1'b0;
      start_ready_q <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_bit_q    <= 1'b0;
      ones_cnt_q    <= '0;
      eval_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      cap_bit_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      c_q           <= c_d;
      vcc_q         <= vcc_d;
      tig_q         <= tig_d;
      start_ready_q <= start_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_bit_q    <= resp_bit_d;
      ones_cnt_q    <= ones_cnt_d;
      eval_cnt_q    <= eval_cnt_d;
      timeout_err_q <= timeout_err_d;
      cap_bit_q     <= cap_bit_d;
    end
  end

  assign c           = c_q;
  assign vcc         = vcc_q;
  assign tigSignal   = tig_q;
  assign start_ready = start_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_bit    = resp_bit_q;
  assign ones_cnt    = ones_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Directed bench for apuf_eval_ctrl with a behavioural arbiter-PUF model.
module tb_apuf_eval_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [63:0] chal_in;
  logic [63:0] c;
  logic        vcc;
  logic        tigSignal;
  logic        respReady;
  logic        respBit;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_bit;
  logic [7:0]  ones_cnt;
  logic        timeout_err;
`ifdef CHAL_LFSR_EN
  logic        auto_mode;
`endif

  int tests = 0;
  int fails = 0;

  // PUF model controls
  logic [15:0] pattern;
  int          hold_extra;
  bit          never_resp;
  int          fires;
  int          stale;
  int          hi_cnt;
  int          hold_left;
  logic        tig_prev;
  logic [63:0] exp_c;
  int          c_bad;

  always #5 clk = ~clk;

  apuf_eval_ctrl dut (
    .clk         (clk),
    .rst         (rst),
`ifdef CHAL_LFSR_EN
    .auto_mode   (auto_mode),
`endif
    .start_valid (start_valid),
    .start_ready (start_ready),
    .chal_in     (chal_in),
    .c           (c),
    .vcc         (vcc),
    .tigSignal   (tigSignal),
    .respReady   (respReady),
    .respBit     (respBit),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_bit    (resp_bit),
    .ones_cnt    (ones_cnt),
    .timeout_err (timeout_err)
  );

  // PUF model: respReady rises in the 3rd trigger-high cycle, falls
  // hold_extra cycles after the trigger drops.
  always @(negedge clk) begin
    if (!tigSignal) begin
      hi_cnt = 0;
      if (respReady) begin
        if (hold_left > 0) hold_left = hold_left - 1;
        else respReady = 1'b0;
      end
    end else begin
      if (!tig_prev) begin
        fires = fires + 1;
        if (respReady) stale = stale + 1;
      end
      hi_cnt = hi_cnt + 1;
      if (!never_resp && hi_cnt == 3 && !respReady) begin
        respReady = 1'b1;
        respBit   = pattern[fires-1];
        hold_left = hold_extra;
      end
    end
    tig_prev = tigSignal;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input logic [63:0] ch, input logic [15:0] pat,
                           input int hold, input bit never);
    @(negedge clk);
    pattern     = pat;
    hold_extra  = hold;
    never_resp  = never;
    fires       = 0;
    stale       = 0;
    c_bad       = 0;
    exp_c       = ch;
    chal_in     = ch;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    chal_in     = ~ch;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (vcc && c !== exp_c) c_bad++;
      if (resp_valid) begin
        cyc = i - 1;
        break;
      end
    end
    chk("done_seen", {63'd0, resp_valid}, 64'd1);
  endtask

  task automatic finish_txn();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("post_ack_valid", {63'd0, resp_valid}, 64'd0);
    chk("post_ack_ready", {63'd0, start_ready}, 64'd1);
    chk("post_ack_vcc", {63'd0, vcc}, 64'd0);
  endtask

  initial begin
    int          cyc;
    int          unstable;
    logic [63:0] hold_c;
    logic [7:0]  hold_ones;
    logic        hold_bit;

    rst = 1'b1; start_valid = 1'b0; chal_in = '0; resp_ready = 1'b0;
    respReady = 1'b0; respBit = 1'b0; pattern = '0; hold_extra = 0;
    never_resp = 1'b0; fires = 0; stale = 0; hi_cnt = 0; hold_left = 0;
    tig_prev = 1'b0; exp_c = '0; c_bad = 0;
`ifdef CHAL_LFSR_EN
    auto_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_ready", {63'd0, start_ready}, 64'd1);
    chk("rst_outs", {58'd0, vcc, tigSignal, resp_valid, resp_bit, timeout_err, |ones_cnt}, 64'd0);
    chk("rst_c", c, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // All ones: 124 edges from accept = 4 setup + 15*(3 fire + 1 capture + 4 relax).
    start_txn(64'hDEAD_BEEF_0123_4567, 16'hFFFF, 0, 1'b0);
    chk("accept_ready_low", {63'd0, start_ready}, 64'd0);
    chk("accept_vcc", {63'd0, vcc}, 64'd1);
    chk("accept_c", c, 64'hDEAD_BEEF_0123_4567);
    wait_done(cyc);
    chk("ones_latency", 64'(cyc), 64'd124);
    chk("ones_cnt15", 64'(ones_cnt), 64'd15);
    chk("ones_bit", {63'd0, resp_bit}, 64'd1);
    chk("ones_terr", {63'd0, timeout_err}, 64'd0);
    chk("ones_fires", 64'(fires), 64'd15);
    chk("ones_c_hold", 64'(c_bad), 64'd0);
    finish_txn();
    chk("idle_ones_hold", 64'(ones_cnt), 64'd15);

    // 7 ones -> 0
    start_txn(64'h1111_2222_3333_4444, 16'h007F, 0, 1'b0);
    wait_done(cyc);
    chk("seven_cnt", 64'(ones_cnt), 64'd7);
    chk("seven_bit", {63'd0, resp_bit}, 64'd0);
    finish_txn();

    // 8 ones -> 1
    start_txn(64'hA5A5_5A5A_0F0F_F0F0, 16'h00FF, 0, 1'b0);
    wait_done(cyc);
    chk("eight_cnt", 64'(ones_cnt), 64'd8);
    chk("eight_bit", {63'd0, resp_bit}, 64'd1);
    finish_txn();

    // No response: DONE after 4 setup + 64 fire edges.
    start_txn(64'h0000_0000_CAFE_F00D, 16'hFFFF, 0, 1'b1);
    wait_done(cyc);
    chk("to_latency", 64'(cyc), 64'd68);
    chk("to_err", {63'd0, timeout_err}, 64'd1);
    chk("to_bit", {63'd0, resp_bit}, 64'd0);
    chk("to_tig", {63'd0, tigSignal}, 64'd0);
    finish_txn();

    // respReady lingers 10 cycles after trigger release.
    start_txn(64'h0123_4567_89AB_CDEF, 16'hFFFF, 10, 1'b0);
    wait_done(cyc);
    chk("hold_fires", 64'(fires), 64'd15);
    chk("hold_stale", 64'(stale), 64'd0);
    chk("hold_cnt", 64'(ones_cnt), 64'd15);
    chk("hold_terr", {63'd0, timeout_err}, 64'd0);
    finish_txn();

    // Reset during the 5th FIRE.
    start_txn(64'h7777_8888_9999_AAAA, 16'hFFFF, 0, 1'b0);
    cyc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (fires == 5) begin
        cyc = 1;
        break;
      end
    end
    chk("fifth_fire_seen", 64'(cyc), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_ready", {63'd0, start_ready}, 64'd1);
    chk("mid_rst_outs", {61'd0, vcc, tigSignal, resp_valid}, 64'd0);
    chk("mid_rst_cnt", 64'(ones_cnt), 64'd0);

    // Fresh run after reset: alternating bits, 8 ones.
    start_txn(64'h0F1E_2D3C_4B5A_6978, 16'h5555, 0, 1'b0);
    wait_done(cyc);
    chk("fresh_cnt", 64'(ones_cnt), 64'd8);
    chk("fresh_bit", {63'd0, resp_bit}, 64'd1);
    chk("fresh_latency", 64'(cyc), 64'd124);

    // Host stalls in DONE while trying to start another transaction.
    hold_c    = c;
    hold_ones = ones_cnt;
    hold_bit  = resp_bit;
    unstable  = 0;
    start_valid = 1'b1;
    chal_in     = 64'hFFFF_0000_FFFF_0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_bit !== hold_bit || ones_cnt !== hold_ones ||
          c !== hold_c || !vcc || start_ready || tigSignal) unstable++;
    end
    start_valid = 1'b0;
    chk("done_stable", 64'(unstable), 64'd0);
    finish_txn();

`ifdef CHAL_LFSR_EN
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      pattern = 16'hFFFF; hold_extra = 0; never_resp = 1'b0; fires = 0; c_bad = 0;
      exp_c = (k == 0) ? 64'h1 : 64'h2;
      chal_in = 64'h1234_5678_9ABC_DEF0;
      auto_mode = 1'b1;
      @(posedge clk);
      #1;
      auto_mode = 1'b0;
      chk("lfsr_c", c, exp_c);
      wait_done(cyc);
      chk("lfsr_cnt", 64'(ones_cnt), 64'd15);
      finish_txn();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
